// File: rtl/axis_drain_pkg.sv
// Shared types and helpers for the FIFO-to-AXIS drain block and its output buffer.
package axis_drain_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  localparam int DEF_DWIDTH = 8;
  localparam int DEF_LWIDTH = 16;
  localparam int DEF_CWIDTH = 16;

  // A zero frame length means streaming: no beat is ever the last one.
  function automatic logic is_last(input logic [31:0] beat_cnt, input logic [31:0] frame_len);
    return (frame_len != 32'd0) && (beat_cnt == (frame_len - 32'd1));
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry valid/ready register buffer; the head entry drives the output.
module axis_skid2
  import axis_drain_pkg::*;
#(
  parameter int W = DEF_DWIDTH + 1
) (
  input  logic         clk,
  input  logic         res,
  input  logic         in_push,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_t   state
);

  buf_state_t   state_r, state_s;
  logic [W-1:0] head_r, head_s;
  logic [W-1:0] tail_r, tail_s;
  logic         valid_r;
  logic         pop_s;

  assign pop_s = valid_r & out_ready;

  // Next-state and data-shift logic for the two-entry buffer.
  always_comb begin
    state_s = state_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (state_r)
      BUF_EMPTY: begin
        if (in_push) begin
          head_s  = in_data;
          state_s = BUF_ONE;
        end else begin
          state_s = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (in_push && pop_s) begin
          head_s = in_data;
        end else if (in_push) begin
          tail_s  = in_data;
          state_s = BUF_TWO;
        end else if (pop_s) begin
          state_s = BUF_EMPTY;
        end else begin
          state_s = BUF_ONE;
        end
      end
      BUF_TWO: begin
        // Pushes cannot arrive here; the producer is gated on state != BUF_TWO.
        if (pop_s) begin
          head_s  = tail_r;
          state_s = BUF_ONE;
        end else begin
          state_s = BUF_TWO;
        end
      end
      default: begin
        state_s = BUF_EMPTY;
      end
    endcase
  end

  // Buffer state, entries and registered valid.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_r <= BUF_EMPTY;
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      head_r  <= head_s;
      tail_r  <= tail_s;
      valid_r <= (state_s != BUF_EMPTY);
    end
  end

  assign out_valid = valid_r;
  assign out_data  = head_r;
  assign state     = state_r;

endmodule

// File: rtl/axis_fifo_drain.sv
// Drains a show-ahead FIFO into an AXI4-Stream master, framing every cfg_frame_len beats.
module axis_fifo_drain
  import axis_drain_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              res,
  input  logic              enable,
  input  logic [LWIDTH-1:0] cfg_frame_len,
  input  logic              fifo_empty,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_read_value,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [CWIDTH-1:0] frames_sent,
  output logic              busy
);

  buf_state_t        buf_state_s;
  logic [DWIDTH:0]   buf_data_s;
  logic              buf_valid_s;
  logic [LWIDTH-1:0] beat_cnt_r, beat_cnt_s;
  logic [LWIDTH-1:0] frame_len_r, len_s;
  logic [CWIDTH-1:0] frames_r;
  logic              last_s;

  assign fifo_read = enable & ~fifo_empty & (buf_state_s != BUF_TWO) & ~res;

  // Frame length for this capture and the tlast / beat counter update.
  always_comb begin
    len_s      = (beat_cnt_r == {LWIDTH{1'b0}}) ? cfg_frame_len : frame_len_r;
    last_s     = is_last(32'(beat_cnt_r), 32'(len_s));
    beat_cnt_s = beat_cnt_r;
    if (last_s) begin
      beat_cnt_s = {LWIDTH{1'b0}};
    end else if (len_s == {LWIDTH{1'b0}}) begin
      // Streaming parks the counter at 1 so the length is not resampled.
      beat_cnt_s = LWIDTH'(1'b1);
    end else begin
      beat_cnt_s = beat_cnt_r + LWIDTH'(1'b1);
    end
  end

  // Beat counter, latched frame length and completed-frame counter.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      beat_cnt_r  <= {LWIDTH{1'b0}};
      frame_len_r <= {LWIDTH{1'b0}};
      frames_r    <= {CWIDTH{1'b0}};
    end else begin
      if (fifo_read) begin
        beat_cnt_r  <= beat_cnt_s;
        frame_len_r <= len_s;
      end
      if (buf_valid_s && m_axis_tready && buf_data_s[0]) begin
        frames_r <= frames_r + CWIDTH'(1'b1);
      end
    end
  end

  axis_skid2 #(
    .W (DWIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .res       (res),
    .in_push   (fifo_read),
    .in_data   ({fifo_read_value, last_s}),
    .out_valid (buf_valid_s),
    .out_ready (m_axis_tready),
    .out_data  (buf_data_s),
    .state     (buf_state_s)
  );

  assign m_axis_tvalid = buf_valid_s;
  assign m_axis_tdata  = buf_data_s[DWIDTH:1];
  assign m_axis_tlast  = buf_data_s[0];
  assign frames_sent   = frames_r;
  assign busy          = buf_valid_s | (beat_cnt_r != {LWIDTH{1'b0}});

endmodule

// File: tb/tb_axis_fifo_drain.sv
// Directed bench for axis_fifo_drain with a queue-based show-ahead FIFO model.
module tb_axis_fifo_drain;

  logic        clk = 1'b0;
  logic        res;
  logic        enable;
  logic [15:0] cfg_frame_len;
  logic        fifo_empty;
  logic        fifo_read;
  logic [7:0]  fifo_read_value;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic [15:0] frames_sent;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [7:0] exp_d[$];
  logic       exp_l[$];
  logic       s_rd, s_tv, s_tl;
  logic [7:0] s_td;

  axis_fifo_drain dut (
    .clk             (clk),
    .res             (res),
    .enable          (enable),
    .cfg_frame_len   (cfg_frame_len),
    .fifo_empty      (fifo_empty),
    .fifo_read       (fifo_read),
    .fifo_read_value (fifo_read_value),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .frames_sent     (frames_sent),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty      = (q.size() == 0);
    fifo_read_value = fifo_empty ? 8'h00 : q[0];
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
    fifo_refresh();
  endtask

  task automatic expect_frame(input logic [7:0] base, input int n, input int len);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(base + 8'(i));
      exp_l.push_back((len != 0) && ((i % len) == (len - 1)));
    end
  endtask

  task automatic apply_reset();
    res = 1'b1;
    q.delete();
    got_d.delete();
    got_l.delete();
    fifo_refresh();
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  // One clock: sample at the falling edge, then apply the FIFO pop just after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_rd = fifo_read;
    s_tv = m_axis_tvalid;
    s_td = m_axis_tdata;
    s_tl = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
    end
    @(posedge clk);
    #1;
    if (s_rd && q.size() > 0) void'(q.pop_front());
    fifo_refresh();
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int c = 0;
    while (got_d.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq({tag, "_beats"}, 32'(got_d.size()), 32'(n));
  endtask

  task automatic check_stream(input string tag);
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), 32'(got_d[i]), 32'(exp_d[i]));
      check_eq($sformatf("%s_l%0d", tag, i), 32'(got_l[i]), 32'(exp_l[i]));
    end
    exp_d.delete();
    exp_l.delete();
    got_d.delete();
    got_l.delete();
  endtask

  initial begin
    res = 1'b1;
    enable = 1'b1;
    cfg_frame_len = 16'd0;
    m_axis_tready = 1'b0;
    q.push_back(8'hAA);
    fifo_refresh();
    #12;
    check_eq("rst_read", 32'(fifo_read), 32'd0);
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("rst_frames", 32'(frames_sent), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Back-to-back frame of 4 at full rate.
    apply_reset();
    cfg_frame_len = 16'd4;
    m_axis_tready = 1'b1;
    load(8'h11, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t1_read%0d", i), 32'(s_rd), 32'd1);
    end
    tick();
    check_eq("t1_read_idle", 32'(s_rd), 32'd0);
    drain("t1", 4, 20);
    expect_frame(8'h11, 4, 4);
    check_stream("t1");
    check_eq("t1_frames", 32'(frames_sent), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // Backpressure fills the buffer; head held, pops stall.
    apply_reset();
    cfg_frame_len = 16'd4;
    m_axis_tready = 1'b0;
    load(8'h11, 8);
    tick();
    check_eq("t2_read0", 32'(s_rd), 32'd1);
    tick();
    check_eq("t2_read1", 32'(s_rd), 32'd1);
    for (int i = 2; i < 5; i++) begin
      tick();
      check_eq($sformatf("t2_stall_read%0d", i), 32'(s_rd), 32'd0);
      check_eq($sformatf("t2_hold_data%0d", i), 32'(s_td), 32'h11);
      check_eq($sformatf("t2_hold_valid%0d", i), 32'(s_tv), 32'd1);
    end
    m_axis_tready = 1'b1;
    drain("t2", 8, 40);
    expect_frame(8'h11, 8, 4);
    check_stream("t2");
    check_eq("t2_frames", 32'(frames_sent), 32'd2);

    // Streaming mode with toggling ready.
    apply_reset();
    cfg_frame_len = 16'd0;
    load(8'h21, 6);
    for (int i = 0; i < 60 && got_d.size() < 6; i++) begin
      m_axis_tready = (i % 2 == 0);
      tick();
    end
    check_eq("t3_beats", 32'(got_d.size()), 32'd6);
    expect_frame(8'h21, 6, 0);
    check_stream("t3");
    check_eq("t3_frames", 32'(frames_sent), 32'd0);
    check_eq("t3_busy_open", 32'(busy), 32'd1);

    // Length change mid-frame applies only from the next frame.
    apply_reset();
    cfg_frame_len = 16'd3;
    m_axis_tready = 1'b1;
    load(8'h31, 4);
    tick();
    tick();
    cfg_frame_len = 16'd5;
    load(8'h35, 4);
    drain("t4", 8, 40);
    for (int i = 0; i < 8; i++) begin
      exp_d.push_back(8'h31 + 8'(i));
      exp_l.push_back(i == 2 || i == 7);
    end
    check_stream("t4");
    check_eq("t4_frames", 32'(frames_sent), 32'd2);

    // Asynchronous reset in the middle of a frame.
    cfg_frame_len = 16'd4;
    load(8'h41, 4);
    tick();
    tick();
    check_eq("t5_pre_valid", 32'(m_axis_tvalid), 32'd1);
    #2 res = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(m_axis_tvalid), 32'd0);
    check_eq("t5_rst_frames", 32'(frames_sent), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_read", 32'(fifo_read), 32'd0);
    q.delete();
    got_d.delete();
    got_l.delete();
    load(8'h45, 4);
    @(posedge clk);
    #3 res = 1'b0;
    drain("t5", 4, 20);
    expect_frame(8'h45, 4, 4);
    check_stream("t5");
    check_eq("t5_frames", 32'(frames_sent), 32'd1);

    // frames_sent wrap: 65535 one-beat frames, then one more.
    apply_reset();
    cfg_frame_len = 16'd1;
    m_axis_tready = 1'b1;
    enable = 1'b1;
    fifo_empty = 1'b0;
    fifo_read_value = 8'h5A;
    repeat (65535) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_frames_max", 32'(frames_sent), 32'h0000FFFF);
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t6_frames_wrap", 32'(frames_sent), 32'h00000000);
    check_eq("t6_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
